// File: rtl/ram_fifo_pkg.sv
// Shared constants and types for the RAM-backed FIFO controller.
package ram_fifo_pkg;

  localparam int unsigned DATAWID = 18;
  localparam int unsigned WEWID   = 2;

  localparam logic [WEWID-1:0] WEB_ALL  = 2'b00;
  localparam logic [WEWID-1:0] WEB_NONE = 2'b11;

  // Accepted-access combination for one cycle, encoded as {push, pop}.
  typedef enum logic [1:0] {
    AccIdle = 2'b00,
    AccPop  = 2'b01,
    AccPush = 2'b10,
    AccBoth = 2'b11
  } acc_e;

endpackage

// File: rtl/ram_fifo_ptr.sv
// FIFO pointer with wrap bit: increments on accepted access, clears on flush or reset.
module ram_fifo_ptr #(
  parameter int unsigned ADDRWID = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             inc,
  output logic [ADDRWID:0] ptr
);

  logic [ADDRWID:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (flush) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr_q + {{ADDRWID{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/ram_fifo_ctl.sv
// Synchronous FIFO controller driving a dual-port RAM (port A write, port B read).
module ram_fifo_ctl
  import ram_fifo_pkg::*;
#(
  parameter int unsigned ADDRWID  = 8,
  parameter int unsigned AE_LEVEL = 4,
  parameter int unsigned AF_LEVEL = (1 << ADDRWID) - 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               FLUSH,
  input  logic               PUSH,
  input  logic [DATAWID-1:0] DIN,
  input  logic               POP,
  output logic [DATAWID-1:0] DOUT,
  output logic               DOUT_VALID,
  output logic               EMPTY,
  output logic               FULL,
  output logic               ALMOST_EMPTY,
  output logic               ALMOST_FULL,
  output logic [ADDRWID:0]   COUNT,
  output logic               OVERRUN,
  output logic               UNDERRUN,
  output logic [ADDRWID-1:0] AA,
  output logic [ADDRWID-1:0] AB,
  output logic               CENA,
  output logic               CENB,
  output logic               WENA,
  output logic               WENB,
  output logic [WEWID-1:0]   WENBA,
  output logic [WEWID-1:0]   WENBB,
  output logic [DATAWID-1:0] DA,
  input  logic [DATAWID-1:0] QB
);

  localparam int unsigned      DEPTH   = 1 << ADDRWID;
  localparam logic [ADDRWID:0] DEPTH_C = DEPTH[ADDRWID:0];
  localparam logic [ADDRWID:0] AE_C    = AE_LEVEL[ADDRWID:0];
  localparam logic [ADDRWID:0] AF_C    = AF_LEVEL[ADDRWID:0];
  localparam logic [ADDRWID:0] ONE_C   = {{ADDRWID{1'b0}}, 1'b1};

  logic               push_ok, pop_ok;
  acc_e               acc;
  logic [ADDRWID:0]   wptr, rptr;
  logic [ADDRWID:0]   count_q, count_d;
  logic               empty_q, full_q, aempty_q, afull_q;
  logic               ovr_q, und_q;
  logic               rd_pend_q, dout_valid_q;
  logic [DATAWID-1:0] dout_q;

  // Flags are registered, so acceptance only depends on PUSH/POP and state.
  // RST gates the enables so the RAM sees no access while reset is held.
  assign push_ok = PUSH & ~full_q & ~FLUSH & ~RST;
  assign pop_ok  = POP & ~empty_q & ~FLUSH & ~RST;
  assign acc     = acc_e'({push_ok, pop_ok});

  ram_fifo_ptr #(
    .ADDRWID (ADDRWID)
  ) u_wptr (
    .clk   (CLK),
    .rst   (RST),
    .flush (FLUSH),
    .inc   (push_ok),
    .ptr   (wptr)
  );

  ram_fifo_ptr #(
    .ADDRWID (ADDRWID)
  ) u_rptr (
    .clk   (CLK),
    .rst   (RST),
    .flush (FLUSH),
    .inc   (pop_ok),
    .ptr   (rptr)
  );

  always_comb begin
    count_d = count_q;
    if (FLUSH) begin
      count_d = '0;
    end else begin
      case (acc)
        AccPush: count_d = count_q + ONE_C;
        AccPop:  count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q      <= '0;
      empty_q      <= 1'b1;
      aempty_q     <= 1'b1;
      full_q       <= 1'b0;
      afull_q      <= 1'b0;
      ovr_q        <= 1'b0;
      und_q        <= 1'b0;
      rd_pend_q    <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
    end else begin
      count_q  <= count_d;
      empty_q  <= (count_d == '0);
      aempty_q <= (count_d <= AE_C);
      full_q   <= (count_d == DEPTH_C);
      afull_q  <= (count_d >= AF_C);
      if (FLUSH) begin
        ovr_q        <= 1'b0;
        und_q        <= 1'b0;
        rd_pend_q    <= 1'b0;
        dout_valid_q <= 1'b0;
        dout_q       <= '0;
      end else begin
        ovr_q        <= ovr_q | (PUSH & full_q);
        und_q        <= und_q | (POP & empty_q);
        // QB is valid the cycle after the RAM read; capture it one edge later.
        rd_pend_q    <= pop_ok;
        dout_valid_q <= rd_pend_q;
        if (rd_pend_q) begin
          dout_q <= QB;
        end
      end
    end
  end

  // The wrap bits make the pointer distance equal the occupancy at all times.
  assert property (@(posedge CLK) disable iff (RST) ((wptr - rptr) == count_q));

  assign AA    = wptr[ADDRWID-1:0];
  assign AB    = rptr[ADDRWID-1:0];
  assign CENA  = ~push_ok;
  assign WENA  = ~push_ok;
  assign WENBA = push_ok ? WEB_ALL : WEB_NONE;
  assign DA    = DIN;
  assign CENB  = ~pop_ok;
  assign WENB  = 1'b1;
  assign WENBB = WEB_NONE;

  assign COUNT        = count_q;
  assign EMPTY        = empty_q;
  assign FULL         = full_q;
  assign ALMOST_EMPTY = aempty_q;
  assign ALMOST_FULL  = afull_q;
  assign OVERRUN      = ovr_q;
  assign UNDERRUN     = und_q;
  assign DOUT         = dout_q;
  assign DOUT_VALID   = dout_valid_q;

endmodule

// File: tb/tb_ram_fifo_ctl.sv
// Randomized self-checking bench for ram_fifo_ctl against a queue-based FIFO model.
module tb_ram_fifo_ctl;

  localparam int DEPTH = 256;

  logic        CLK = 1'b0;
  logic        RST, FLUSH, PUSH, POP;
  logic [17:0] DIN;
  logic [17:0] DOUT;
  logic        DOUT_VALID, EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL;
  logic [8:0]  COUNT;
  logic        OVERRUN, UNDERRUN;
  logic [7:0]  AA, AB;
  logic        CENA, CENB, WENA, WENB;
  logic [1:0]  WENBA, WENBB;
  logic [17:0] DA;
  logic [17:0] QB = '0;

  int vectors = 0;
  int errors  = 0;
  bit chk_en  = 1'b0;

  ram_fifo_ctl dut (
    .CLK          (CLK),
    .RST          (RST),
    .FLUSH        (FLUSH),
    .PUSH         (PUSH),
    .DIN          (DIN),
    .POP          (POP),
    .DOUT         (DOUT),
    .DOUT_VALID   (DOUT_VALID),
    .EMPTY        (EMPTY),
    .FULL         (FULL),
    .ALMOST_EMPTY (ALMOST_EMPTY),
    .ALMOST_FULL  (ALMOST_FULL),
    .COUNT        (COUNT),
    .OVERRUN      (OVERRUN),
    .UNDERRUN     (UNDERRUN),
    .AA           (AA),
    .AB           (AB),
    .CENA         (CENA),
    .CENB         (CENB),
    .WENA         (WENA),
    .WENB         (WENB),
    .WENBA        (WENBA),
    .WENBB        (WENBB),
    .DA           (DA),
    .QB           (QB)
  );

  always #5 CLK = ~CLK;

  // Behavioural dual-port RAM: write on A, registered read on B.
  logic [17:0] mem [DEPTH];
  always @(posedge CLK) begin
    if (!CENA && !WENA && WENBA == 2'b00) mem[AA] <= DA;
    if (!CENB) QB <= mem[AB];
  end

  // Reference model: queue of stored words plus a one-deep read pipeline.
  logic [17:0] m_q[$];
  bit          m_ovr, m_und, m_dv, m_pend, m_pa, m_pp;
  logic [17:0] m_dout, m_pend_data;
  int          m_wr, m_rd;

  task automatic m_clear();
    m_q.delete();
    m_ovr = 0; m_und = 0; m_dv = 0; m_pend = 0;
    m_dout = '0; m_pend_data = '0;
    m_wr = 0; m_rd = 0;
  endtask

  always @(posedge CLK or posedge RST) begin
    if (RST || FLUSH) begin
      m_clear();
    end else begin
      m_dv = m_pend;
      if (m_pend) m_dout = m_pend_data;
      m_pa = PUSH && (m_q.size() < DEPTH);
      m_pp = POP && (m_q.size() > 0);
      if (PUSH && m_q.size() == DEPTH) m_ovr = 1;
      if (POP && m_q.size() == 0) m_und = 1;
      m_pend = m_pp;
      if (m_pp) begin
        m_pend_data = m_q.pop_front();
        m_rd++;
      end
      if (m_pa) begin
        m_q.push_back(DIN);
        m_wr++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  bit e_pa, e_pp;
  always @(negedge CLK) begin
    if (chk_en) begin
      e_pa = !RST && !FLUSH && PUSH && (m_q.size() < DEPTH);
      e_pp = !RST && !FLUSH && POP && (m_q.size() > 0);
      chk("count", COUNT, m_q.size());
      chk("empty", EMPTY, m_q.size() == 0);
      chk("full", FULL, m_q.size() == DEPTH);
      chk("almost_empty", ALMOST_EMPTY, m_q.size() <= 4);
      chk("almost_full", ALMOST_FULL, m_q.size() >= DEPTH - 4);
      chk("overrun", OVERRUN, m_ovr);
      chk("underrun", UNDERRUN, m_und);
      chk("dout_valid", DOUT_VALID, m_dv);
      chk("dout", DOUT, m_dout);
      chk("cena", CENA, !e_pa);
      chk("wena", WENA, !e_pa);
      chk("wenba", WENBA, e_pa ? 2'b00 : 2'b11);
      chk("cenb", CENB, !e_pp);
      chk("wenb", WENB, 1'b1);
      chk("wenbb", WENBB, 2'b11);
      if (e_pa) begin
        chk("aa", AA, m_wr % DEPTH);
        chk("da", DA, DIN);
      end
      if (e_pp) chk("ab", AB, m_rd % DEPTH);
      if (!CENA && !CENB) chk("aa_ne_ab", AA != AB, 1'b1);
    end
  end

  logic [17:0] got[$];
  always @(negedge CLK) begin
    if (DOUT_VALID === 1'b1) got.push_back(DOUT);
  end

  task automatic tick(input logic p, input logic [17:0] d, input logic r, input logic f);
    PUSH = p; DIN = d; POP = r; FLUSH = f;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pp, rp;
    RST = 1'b1; PUSH = 1'b0; POP = 1'b0; FLUSH = 1'b0; DIN = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk_en = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("rst_count", COUNT, 0);
    chk("rst_empty", EMPTY, 1);
    chk("rst_cena", CENA, 1);
    chk("rst_cenb", CENB, 1);
    chk("rst_dv", DOUT_VALID, 0);

    // Ordered push/pop of five words.
    got.delete();
    for (int i = 1; i <= 5; i++) tick(1, 18'(i), 0, 0);
    for (int i = 0; i < 5; i++) tick(0, 0, 1, 0);
    repeat (3) tick(0, 0, 0, 0);
    chk("seq_n", got.size(), 5);
    for (int i = 0; i < 5; i++) chk("seq_data", got[i], i + 1);
    chk("seq_empty", EMPTY, 1);

    // Fill, then one push too many.
    for (int i = 0; i < DEPTH; i++) tick(1, 18'($urandom), 0, 0);
    chk("fill_count", COUNT, 256);
    chk("fill_full", FULL, 1);
    PUSH = 1'b1; DIN = 18'h3ffff;
    #3;
    chk("ovf_cena", CENA, 1);
    @(posedge CLK);
    #1;
    PUSH = 1'b0;
    chk("ovf_count", COUNT, 256);
    chk("ovf_flag", OVERRUN, 1);

    // Steady push+pop at COUNT=10 across pointer wrap.
    for (int i = 0; i < DEPTH - 10; i++) tick(0, 0, 1, 0);
    chk("pp_start", COUNT, 10);
    for (int i = 0; i < 300; i++) tick(1, 18'($urandom), 1, 0);
    chk("pp_count", COUNT, 10);
    for (int i = 0; i < 10; i++) tick(0, 0, 1, 0);
    repeat (2) tick(0, 0, 0, 0);

    // Pop while empty, then push+pop while empty.
    POP = 1'b1;
    #3;
    chk("und_cenb", CENB, 1);
    @(posedge CLK);
    #1;
    POP = 1'b0;
    chk("und_flag", UNDERRUN, 1);
    got.delete();
    tick(1, 18'h2a5a5, 1, 0);
    repeat (2) tick(0, 0, 0, 0);
    chk("pe_count", COUNT, 1);
    chk("pe_no_valid", got.size(), 0);

    // Flush at COUNT=100.
    for (int i = 0; i < 99; i++) tick(1, 18'($urandom), 0, 0);
    chk("fl_pre", COUNT, 100);
    tick(0, 0, 0, 1);
    chk("fl_count", COUNT, 0);
    chk("fl_empty", EMPTY, 1);
    chk("fl_ovr", OVERRUN, 0);
    chk("fl_und", UNDERRUN, 0);

    // Reset mid-pop at COUNT=100.
    for (int i = 0; i < 100; i++) tick(1, 18'($urandom), 0, 0);
    got.delete();
    POP = 1'b1;
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    chk("rp_count", COUNT, 0);
    chk("rp_dv", DOUT_VALID, 0);
    chk("rp_empty", EMPTY, 1);
    POP = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    repeat (3) tick(0, 0, 0, 0);
    chk("rp_no_valid", got.size(), 0);

    // Random traffic with shifting push/pop bias.
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) begin
        pp = $urandom_range(10, 95);
        rp = $urandom_range(10, 95);
      end
      tick($urandom_range(0, 99) < pp, 18'($urandom), $urandom_range(0, 99) < rp,
           $urandom_range(0, 299) == 0);
    end
    repeat (3) tick(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
